// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states and field widths.
package imem_loader_pkg;

  localparam int LEN_W  = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    HDR_LO = 3'd0,
    HDR_HI = 3'd1,
    DATA   = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } state_t;

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// Assembles little-endian 32-bit words from a byte stream; the first byte lands in bits [7:0].
import imem_loader_pkg::*;

module byte_word_packer (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              word_valid,
  output logic [31:0]       word
);

  logic [1:0]  lane;
  logic [23:0] lo;

  // Lane counter and storage for the first three bytes; clr discards a partial word.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      lane <= '0;
      lo   <= '0;
    end else if (byte_en) begin
      lane <= lane + 2'd1;
      case (lane)
        2'd0:    lo[7:0]   <= byte_in;
        2'd1:    lo[15:8]  <= byte_in;
        2'd2:    lo[23:16] <= byte_in;
        default: ;
      endcase
    end
  end

  // The fourth byte completes the word directly from the input, so no extra cycle is needed.
  always_comb begin
    word_valid = byte_en && (lane == 2'd3);
    word       = {byte_in, lo};
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed program image from a byte stream into instruction memory,
// holding the CPU in reset until the image is fully written.
import imem_loader_pkg::*;

module imem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] word_cnt;
  logic [LEN_W-1:0] hdr_len;
  logic             xfer;
  logic             pack_en;
  logic             word_valid;
  logic [31:0]      word;
  logic             last_word;

  byte_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (start),
    .byte_en    (pack_en),
    .byte_in    (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  // Handshake and decode helpers; a start pulse swallows any concurrent byte.
  always_comb begin
    in_ready  = (state == HDR_LO) || (state == HDR_HI) || (state == DATA);
    xfer      = in_valid && in_ready && !start;
    pack_en   = xfer && (state == DATA);
    hdr_len   = {in_data, len[7:0]};
    last_word = (word_cnt + 16'd1) == len;
    done      = (state == DONE);
    err       = (state == ERR);
    cpu_hold  = (state != DONE);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst || start) state <= HDR_LO;
    else              state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      HDR_LO: if (xfer) state_nxt = HDR_HI;
      HDR_HI: begin
        if (xfer) begin
          if (hdr_len == '0)                   state_nxt = DONE;
          else if (hdr_len > LEN_W'(DEPTH))    state_nxt = ERR;
          else                                 state_nxt = DATA;
        end
      end
      DATA:    if (word_valid && last_word) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      ERR:     state_nxt = ERR;
      default: state_nxt = HDR_LO;
    endcase
  end

  // Length capture, word counter and registered write port.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      len      <= '0;
      word_cnt <= '0;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
    end else begin
      we <= 1'b0;
      if (xfer && (state == HDR_LO)) len[7:0]  <= in_data;
      if (xfer && (state == HDR_HI)) len[15:8] <= in_data;
      if (word_valid) begin
        we       <= 1'b1;
        waddr    <= word_cnt[ADDR_W-1:0];
        wdata    <= word;
        word_cnt <= word_cnt + 16'd1;
      end
    end
  end

endmodule
